// File: rtl/basys_pkg.sv
// rtl/basys_pkg.sv - shared switch-select constants and debounce state type
package basys_pkg;

    localparam int NUM_SW = 15;
    localparam int IDX_W  = 4;

    typedef enum logic [0:0] {
        ST_STABLE   = 1'b0,
        ST_SETTLING = 1'b1
    } db_state_t;

endpackage

// File: rtl/onehot_idx_enc.sv
// rtl/onehot_idx_enc.sv - one-hot switch vector to register index encoder
module onehot_idx_enc
    import basys_pkg::*;
(
    input  logic [NUM_SW-1:0] vec,
    output logic [IDX_W-1:0]  idx,
    output logic              valid
);

    logic [IDX_W-1:0] pos;

    always_comb begin
        pos   = '0;
        valid = 1'b0;
        for (int i = 0; i < NUM_SW; i++) begin
            if (vec[i]) begin
                pos = IDX_W'(i);
            end
        end
        // Exactly one bit set: nonzero and clearing the lowest set bit leaves nothing
        valid = (vec != '0) && ((vec & (vec - NUM_SW'(1))) == '0);
        idx   = valid ? pos : '0;
    end

endmodule

// File: rtl/sw_select_debounce.sv
// rtl/sw_select_debounce.sv - synchronized, debounced switch vector to register index
module sw_select_debounce
    import basys_pkg::*;
#(
    parameter int DB_CYCLES = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NUM_SW-1:0] sw,
    output logic [IDX_W-1:0]  reg_idx,
    output logic              idx_valid,
    output logic              idx_changed,
    output logic              busy
);

    localparam int CNT_W = $clog2(DB_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

    logic [NUM_SW-1:0] sync1;
    logic [NUM_SW-1:0] sync2;
    logic [NUM_SW-1:0] candidate;
    logic [NUM_SW-1:0] accepted;
    logic [CNT_W-1:0]  count;
    db_state_t         state;

    logic [IDX_W-1:0]  enc_idx;
    logic              enc_valid;

    onehot_idx_enc u_enc (
        .vec   (candidate),
        .idx   (enc_idx),
        .valid (enc_valid)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1       <= '0;
            sync2       <= '0;
            candidate   <= '0;
            accepted    <= '0;
            count       <= '0;
            state       <= ST_STABLE;
            reg_idx     <= '0;
            idx_valid   <= 1'b0;
            idx_changed <= 1'b0;
            busy        <= 1'b0;
        end else begin
            sync1       <= sw;
            sync2       <= sync1;
            idx_changed <= 1'b0;
            case (state)
                ST_STABLE: begin
                    if (sync2 != accepted) begin
                        candidate <= sync2;
                        count     <= '0;
                        state     <= ST_SETTLING;
                        busy      <= 1'b1;
                    end
                end
                ST_SETTLING: begin
                    if (sync2 == candidate) begin
                        if (count == CNT_LAST) begin
                            accepted    <= candidate;
                            count       <= '0;
                            state       <= ST_STABLE;
                            busy        <= 1'b0;
                            reg_idx     <= enc_idx;
                            idx_valid   <= enc_valid;
                            idx_changed <= ({enc_idx, enc_valid} != {reg_idx, idx_valid});
                        end else begin
                            count <= count + CNT_W'(1);
                        end
                    end else if (sync2 == accepted) begin
                        // Input bounced back to the committed value: drop the attempt
                        count <= '0;
                        state <= ST_STABLE;
                        busy  <= 1'b0;
                    end else begin
                        candidate <= sync2;
                        count     <= '0;
                    end
                end
                default: begin
                    state <= ST_STABLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sw_select_debounce.sv
// tb/tb_sw_select_debounce.sv - scoreboard bench for sw_select_debounce
module tb_sw_select_debounce;
    import basys_pkg::*;

    localparam int DB = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [14:0] sw = '0;
    logic [3:0]  reg_idx;
    logic        idx_valid;
    logic        idx_changed;
    logic        busy;

    sw_select_debounce #(.DB_CYCLES(DB)) dut (
        .clk         (clk),
        .reset       (reset),
        .sw          (sw),
        .reg_idx     (reg_idx),
        .idx_valid   (idx_valid),
        .idx_changed (idx_changed),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] idx;
        logic       valid;
        int         cyc;
    } exp_t;

    exp_t q[$];

    int checks = 0;
    int failures = 0;
    int cycle = 0;
    int pulses = 0;
    int busy_cycles = 0;
    int last_pulse_cycle = -1;

    // Reference model: a value is accepted once the two-cycle-delayed input has
    // shown it, different from the accepted value, for DB+1 samples in a row.
    logic [14:0] m_d1 = '0, m_d2 = '0, m_acc = '0, m_cand = '0;
    int          m_run = 0;
    logic [3:0]  m_idx = '0;
    logic        m_valid = 1'b0;
    logic        m_busy = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h cycle=%0d", name, act, req, cycle);
        end
    endtask

    function automatic void ref_enc(input logic [14:0] v, output logic [3:0] i, output logic ok);
        ok = ($countones(v) == 1);
        i  = '0;
        if (ok) begin
            for (int k = 0; k < 15; k++) begin
                if (v[k]) i = 4'(k);
            end
        end
    endfunction

    initial begin
        logic [14:0] smp;
        logic [3:0]  ni;
        logic        nv;
        forever begin
            @(posedge clk);
            cycle++;
            if (reset) begin
                m_d1 = '0; m_d2 = '0; m_acc = '0; m_cand = '0; m_run = 0;
                m_idx = '0; m_valid = 1'b0; m_busy = 1'b0;
                q.delete();
            end else begin
                smp  = m_d2;
                m_d2 = m_d1;
                m_d1 = sw;
                if (smp == m_acc) begin
                    m_run  = 0;
                    m_busy = 1'b0;
                end else begin
                    if (m_run > 0 && smp == m_cand) begin
                        m_run++;
                    end else begin
                        m_cand = smp;
                        m_run  = 1;
                    end
                    m_busy = 1'b1;
                    if (m_run == DB + 1) begin
                        m_acc  = m_cand;
                        m_run  = 0;
                        m_busy = 1'b0;
                        ref_enc(m_acc, ni, nv);
                        if (ni != m_idx || nv != m_valid) begin
                            q.push_back('{idx: ni, valid: nv, cyc: cycle});
                        end
                        m_idx   = ni;
                        m_valid = nv;
                    end
                end
            end
        end
    end

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (cycle > 0) begin
                check("busy", 32'(busy), 32'(m_busy));
                check("reg_idx", 32'(reg_idx), 32'(m_idx));
                check("idx_valid", 32'(idx_valid), 32'(m_valid));
                if (busy) busy_cycles++;
                while (q.size() > 0 && q[0].cyc < cycle) begin
                    check("idx_changed_missing", 32'd0, 32'd1);
                    void'(q.pop_front());
                end
                if (idx_changed) begin
                    pulses++;
                    last_pulse_cycle = cycle;
                    if (q.size() == 0) begin
                        check("idx_changed_spurious", 32'd1, 32'd0);
                    end else begin
                        e = q.pop_front();
                        check("pulse_idx", 32'(reg_idx), 32'(e.idx));
                        check("pulse_valid", 32'(idx_valid), 32'(e.valid));
                        check("pulse_cycle", 32'(cycle), 32'(e.cyc));
                    end
                end
            end
        end
    end

    task automatic drive(input logic [14:0] v, input int n);
        sw = v;
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    initial begin
        int c0, p0, b0, n;
        logic [14:0] v;
        repeat (3) @(posedge clk);
        #2;
        check("reset_reg_idx", 32'(reg_idx), 32'd0);
        check("reset_idx_valid", 32'(idx_valid), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_idx_changed", 32'(idx_changed), 32'd0);
        reset = 1'b0;

        c0 = cycle;
        drive(15'h0001, 12);
        check("r025_idx", 32'(reg_idx), 32'd0);
        check("r025_valid", 32'(idx_valid), 32'd1);
        check("r025_edge", 32'(last_pulse_cycle), 32'(c0 + 7));

        p0 = pulses; b0 = busy_cycles;
        drive(15'h0080, 12);
        check("r026_idx", 32'(reg_idx), 32'd7);
        check("r026_valid", 32'(idx_valid), 32'd1);
        check("r026_pulses", 32'(pulses - p0), 32'd1);
        check("r026_busy_cycles", 32'(busy_cycles - b0), 32'd4);

        p0 = pulses;
        drive(15'h0000, 12);
        check("r027_zero_valid", 32'(idx_valid), 32'd0);
        drive(15'h0101, 12);
        check("r027_multi_idx", 32'(reg_idx), 32'd0);
        check("r027_multi_valid", 32'(idx_valid), 32'd0);
        check("r027_pulses", 32'(pulses - p0), 32'd1);

        drive(15'h0100, 12);
        p0 = pulses;
        drive(15'h0200, 2);
        drive(15'h0100, 12);
        check("r028_idx", 32'(reg_idx), 32'd8);
        check("r028_busy", 32'(busy), 32'd0);
        check("r028_pulses", 32'(pulses - p0), 32'd0);

        drive(15'h0200, 3);
        reset = 1'b1;
        @(posedge clk);
        #2;
        reset = 1'b0;
        check("r029_rst_idx", 32'(reg_idx), 32'd0);
        check("r029_rst_valid", 32'(idx_valid), 32'd0);
        check("r029_rst_busy", 32'(busy), 32'd0);
        check("r029_rst_changed", 32'(idx_changed), 32'd0);
        c0 = cycle;
        drive(15'h0200, 12);
        check("r029_idx", 32'(reg_idx), 32'd9);
        check("r029_valid", 32'(idx_valid), 32'd1);
        check("r029_edge", 32'(last_pulse_cycle), 32'(c0 + 7));

        for (int it = 0; it < 300; it++) begin
            n = $urandom_range(0, 9);
            if (n <= 5)      v = 15'(1) << $urandom_range(0, 14);
            else if (n == 6) v = '0;
            else             v = 15'($urandom);
            if (n == 9) begin
                reset = 1'b1;
                @(posedge clk);
                #2;
                reset = 1'b0;
            end
            drive(v, $urandom_range(1, 9));
        end
        drive(sw, 20);
        check("queue_drained", 32'(q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
